// File: rtl/block_dispatcher.sv
// Dynamic block dispatcher: hands kernel block indices to NUM_PB processing blocks as slots free up.
// Latency: first pb_start one edge after launch acceptance; then at most one dispatch per edge.
// Backpressure: launch_ready low outside IDLE; dispatch stalls while no slot is free in busy_mask.
//
// Ports:
//   clock, reset                  rising-edge clock, asynchronous active-high reset
//   launch_valid/launch_ready     kernel launch handshake; launch_blocks sampled on handshake
//   pb_finished[NUM_PB]           per-PB completion pulse for the block it was given
//   pb_start[NUM_PB]              per-PB start pulse; index in pb_block_idx[p*IDX_W +: IDX_W]
//   busy_mask[NUM_PB]             per-PB slot occupied
//   blocks_retired                completed blocks of the current kernel
//   kernel_done                   one-cycle pulse when every launched block has retired
//   err_spurious                  sticky: completion pulse seen on an idle slot
module block_dispatcher #(
    parameter int NUM_PB = 8,
    parameter int IDX_W  = 16
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic                    launch_valid,
    input  logic [IDX_W-1:0]        launch_blocks,
    output logic                    launch_ready,
    input  logic [NUM_PB-1:0]       pb_finished,
    output logic [NUM_PB-1:0]       pb_start,
    output logic [NUM_PB*IDX_W-1:0] pb_block_idx,
    output logic [NUM_PB-1:0]       busy_mask,
    output logic [IDX_W-1:0]        blocks_retired,
    output logic                    kernel_done,
    output logic                    err_spurious
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t                    state_q, state_d;
    logic [IDX_W-1:0]          total_q, total_d;
    logic [IDX_W-1:0]          next_idx_q, next_idx_d;
    logic [IDX_W-1:0]          retired_d;
    logic [NUM_PB-1:0]         busy_d;
    logic [NUM_PB-1:0]         start_d;
    logic [NUM_PB*IDX_W-1:0]   idx_d;
    logic                      done_d;
    logic                      err_d;

    logic [NUM_PB-1:0]         fin_hit;
    logic [NUM_PB-1:0]         fin_spur;
    logic [NUM_PB-1:0]         free_slots;
    logic [NUM_PB-1:0]         pick;
    logic [IDX_W-1:0]          fin_cnt;

    assign launch_ready = (state_q == ST_IDLE);

    // Finishes only count against occupied slots; anything else is a protocol error.
    assign fin_hit    = pb_finished & busy_mask;
    assign fin_spur   = pb_finished & ~busy_mask;
    assign free_slots = ~busy_mask;
    // Two's-complement trick isolates the lowest set bit: lowest-index free slot.
    assign pick       = free_slots & (~free_slots + NUM_PB'(1));

    always_comb begin
        fin_cnt = '0;
        for (int p = 0; p < NUM_PB; p++) begin
            fin_cnt = fin_cnt + IDX_W'(fin_hit[p]);
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q        <= ST_IDLE;
            total_q        <= '0;
            next_idx_q     <= '0;
            blocks_retired <= '0;
            busy_mask      <= '0;
            pb_start       <= '0;
            pb_block_idx   <= '0;
            kernel_done    <= 1'b0;
            err_spurious   <= 1'b0;
        end else begin
            state_q        <= state_d;
            total_q        <= total_d;
            next_idx_q     <= next_idx_d;
            blocks_retired <= retired_d;
            busy_mask      <= busy_d;
            pb_start       <= start_d;
            pb_block_idx   <= idx_d;
            kernel_done    <= done_d;
            err_spurious   <= err_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        total_d    = total_q;
        next_idx_d = next_idx_q;
        retired_d  = blocks_retired;
        busy_d     = busy_mask;
        start_d    = '0;
        idx_d      = pb_block_idx;
        done_d     = 1'b0;
        err_d      = err_spurious | (|fin_spur);

        case (state_q)
            ST_IDLE: begin
                if (launch_valid) begin
                    total_d    = launch_blocks;
                    next_idx_d = '0;
                    retired_d  = '0;
                    // A new kernel starts with a clean error flag; only this cycle's
                    // stray pulses can mark it.
                    err_d      = |fin_spur;
                    if (launch_blocks == '0) begin
                        state_d = ST_DONE;
                        done_d  = 1'b1;
                    end else begin
                        state_d = ST_RUN;
                    end
                end
            end

            ST_RUN: begin
                busy_d    = busy_mask & ~fin_hit;
                retired_d = blocks_retired + fin_cnt;
                // Dispatch looks only at the pre-edge busy_mask, so a slot freed this
                // edge is reused no earlier than the next one.
                if ((next_idx_q < total_q) && (|free_slots)) begin
                    start_d    = pick;
                    busy_d     = busy_d | pick;
                    next_idx_d = next_idx_q + IDX_W'(1);
                    for (int p = 0; p < NUM_PB; p++) begin
                        if (pick[p]) begin
                            idx_d[p*IDX_W +: IDX_W] = next_idx_q;
                        end
                    end
                end
                if (retired_d == total_q) begin
                    state_d = ST_DONE;
                    done_d  = 1'b1;
                end
            end

            ST_DONE: begin
                state_d = ST_IDLE;
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_block_dispatcher.sv
module tb_block_dispatcher;

    localparam int NUM_PB = 8;
    localparam int IDX_W  = 16;
    localparam int LAT    = 5;

    logic                    clock = 1'b0;
    logic                    reset = 1'b1;
    logic                    launch_valid = 1'b0;
    logic [IDX_W-1:0]        launch_blocks = '0;
    logic                    launch_ready;
    logic [NUM_PB-1:0]       pb_finished = '0;
    logic [NUM_PB-1:0]       pb_start;
    logic [NUM_PB*IDX_W-1:0] pb_block_idx;
    logic [NUM_PB-1:0]       busy_mask;
    logic [IDX_W-1:0]        blocks_retired;
    logic                    kernel_done;
    logic                    err_spurious;

    block_dispatcher #(.NUM_PB(NUM_PB), .IDX_W(IDX_W)) dut (
        .clock          (clock),
        .reset          (reset),
        .launch_valid   (launch_valid),
        .launch_blocks  (launch_blocks),
        .launch_ready   (launch_ready),
        .pb_finished    (pb_finished),
        .pb_start       (pb_start),
        .pb_block_idx   (pb_block_idx),
        .busy_mask      (busy_mask),
        .blocks_retired (blocks_retired),
        .kernel_done    (kernel_done),
        .err_spurious   (err_spurious)
    );

    always #5 clock = ~clock;

    int                n_cmp = 0;
    int                n_err = 0;
    int                exp_q[$];
    int                done_cnt = 0;
    logic [NUM_PB-1:0] prev_busy = '0;
    bit                auto_mode = 1'b0;
    int                cd[NUM_PB];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Advance one clock; sample outputs on the falling edge, score any starts,
    // and (in auto mode) emulate PBs that finish LAT cycles after starting.
    task automatic tick();
        logic [NUM_PB-1:0] fin;
        int e;
        @(posedge clock);
        @(negedge clock);
        chk("start_onehot", 32'($countones(pb_start) <= 1), 1);
        fin = '0;
        if (auto_mode) begin
            for (int p = 0; p < NUM_PB; p++) begin
                if (cd[p] > 0) begin
                    cd[p]--;
                    if (cd[p] == 0) fin[p] = 1'b1;
                end
            end
        end
        for (int p = 0; p < NUM_PB; p++) begin
            if (pb_start[p]) begin
                chk("start_on_free_slot", 32'(prev_busy[p]), 0);
                chk("start_expected", 32'(exp_q.size() != 0), 1);
                if (exp_q.size() != 0) begin
                    e = exp_q.pop_front();
                    chk("start_idx", 32'(pb_block_idx[p*IDX_W +: IDX_W]), 32'(e));
                end
                if (auto_mode) cd[p] = LAT;
            end
        end
        if (auto_mode) pb_finished = fin;
        if (kernel_done) done_cnt++;
        prev_busy = busy_mask;
    endtask

    task automatic launch(input int n);
        launch_blocks = IDX_W'(n);
        launch_valid  = 1'b1;
        for (int i = 0; i < n; i++) exp_q.push_back(i);
        tick();
        launch_valid  = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bit seen;
        for (int p = 0; p < NUM_PB; p++) cd[p] = 0;

        // Reset state
        repeat (2) @(negedge clock);
        chk("rst_ready", 32'(launch_ready), 1);
        chk("rst_busy", 32'(busy_mask), 0);
        chk("rst_start", 32'(pb_start), 0);
        chk("rst_done", 32'(kernel_done), 0);
        reset = 1'b0;
        tick();

        // Small kernel: 3 blocks
        launch(3);
        chk("small_ready_low", 32'(launch_ready), 0);
        chk("small_no_start_at_T", 32'(pb_start), 0);
        tick(); chk("small_start0", 32'(pb_start), 32'h01);
        tick(); chk("small_start1", 32'(pb_start), 32'h02);
        tick(); chk("small_start2", 32'(pb_start), 32'h04);
        tick(); chk("small_idle_start", 32'(pb_start), 0);
        chk("small_busy", 32'(busy_mask), 32'h07);
        pb_finished = 8'h07;
        tick();
        pb_finished = '0;
        chk("small_retired", 32'(blocks_retired), 3);
        chk("small_done", 32'(kernel_done), 1);
        chk("small_busy_clr", 32'(busy_mask), 0);
        chk("small_idx_held", 32'(pb_block_idx[2*IDX_W +: IDX_W]), 2);
        tick();
        chk("small_done_pulse", 32'(kernel_done), 0);
        chk("small_ready_back", 32'(launch_ready), 1);
        chk("small_done_cnt", 32'(done_cnt), 1);

        // Oversubscribed: 20 blocks, PBs finish LAT cycles after start
        auto_mode = 1'b1;
        launch(20);
        seen = 1'b0;
        for (int c = 0; c < 300 && !seen; c++) begin
            tick();
            if (kernel_done) seen = 1'b1;
        end
        auto_mode = 1'b0;
        pb_finished = '0;
        chk("ovr_done_seen", 32'(seen), 1);
        chk("ovr_all_started", 32'(exp_q.size()), 0);
        chk("ovr_retired", 32'(blocks_retired), 20);
        chk("ovr_no_err", 32'(err_spurious), 0);
        tick();
        chk("ovr_done_cnt", 32'(done_cnt), 2);

        // Simultaneous finish: 10 blocks, slots 2 and 5 finish together
        launch(10);
        repeat (8) tick();
        chk("sim_all_busy", 32'(busy_mask), 32'hFF);
        pb_finished = 8'b0010_0100;
        tick();
        pb_finished = '0;
        chk("sim_retired2", 32'(blocks_retired), 2);
        chk("sim_busy_clr", 32'(busy_mask), 32'hDB);
        chk("sim_no_start_E", 32'(pb_start), 0);
        tick(); chk("sim_start_pb2", 32'(pb_start), 32'h04);
        tick(); chk("sim_start_pb5", 32'(pb_start), 32'h20);
        pb_finished = 8'hFF;
        tick();
        pb_finished = '0;
        chk("sim_retired", 32'(blocks_retired), 10);
        chk("sim_done", 32'(kernel_done), 1);
        chk("sim_idx_slot5", 32'(pb_block_idx[5*IDX_W +: IDX_W]), 9);
        tick();
        chk("sim_done_cnt", 32'(done_cnt), 3);

        // Zero launch
        launch(0);
        chk("zero_done", 32'(kernel_done), 1);
        chk("zero_no_start", 32'(pb_start), 0);
        chk("zero_ready_low", 32'(launch_ready), 0);
        tick();
        chk("zero_done_pulse", 32'(kernel_done), 0);
        chk("zero_ready", 32'(launch_ready), 1);
        chk("zero_done_cnt", 32'(done_cnt), 4);

        // Spurious finish on an idle slot
        pb_finished = 8'h10;
        tick();
        pb_finished = '0;
        chk("spur_set", 32'(err_spurious), 1);
        chk("spur_retired", 32'(blocks_retired), 0);
        tick(); tick();
        chk("spur_sticky", 32'(err_spurious), 1);

        // Launch clears the error; reset mid-run abandons the kernel
        launch(6);
        chk("spur_clr_on_launch", 32'(err_spurious), 0);
        repeat (4) tick();
        chk("mid_busy4", 32'(busy_mask), 32'h0F);
        #2 reset = 1'b1;
        #1;
        chk("async_busy", 32'(busy_mask), 0);
        chk("async_start", 32'(pb_start), 0);
        chk("async_ready", 32'(launch_ready), 1);
        chk("async_retired", 32'(blocks_retired), 0);
        chk("async_idx", 32'(pb_block_idx[3*IDX_W +: IDX_W]), 0);
        chk("async_err", 32'(err_spurious), 0);
        exp_q.delete();
        tick(); tick();
        reset = 1'b0;
        chk("rst_no_done", 32'(done_cnt), 4);

        // Relaunch restarts from index 0
        launch(2);
        tick(); chk("re_start0", 32'(pb_start), 32'h01);
        tick(); chk("re_start1", 32'(pb_start), 32'h02);
        pb_finished = 8'h03;
        tick();
        pb_finished = '0;
        chk("re_done", 32'(kernel_done), 1);
        tick();
        chk("re_done_cnt", 32'(done_cnt), 5);
        chk("re_all_started", 32'(exp_q.size()), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
